// File: rtl/dump_sequencer_if.sv
// Bundle of the dump sequencer's request, pipeline-latch, register/memory read
// and TX FIFO signals; slave is the sequencer side, master the surrounding system.
interface dump_sequencer_if #(
    parameter int MEM_ADDR_WIDTH = 8
);
    logic                      i_start;
    logic [63:0]               i_IF_ID_latch;
    logic [138:0]              i_ID_EX_latch;
    logic [75:0]               i_EX_MEM_latch;
    logic [70:0]               i_MEM_WB_latch;
    logic [4:0]                o_reg_addr;
    logic [31:0]               i_reg_content;
    logic [MEM_ADDR_WIDTH-1:0] o_mem_addr;
    logic [31:0]               i_mem_content;
    logic [31:0]               o_fifo_data;
    logic                      o_fifo_wr;
    logic                      i_fifo_full;
    logic                      o_busy;
    logic                      o_done;

    modport slave (
        input  i_start,
        input  i_IF_ID_latch,
        input  i_ID_EX_latch,
        input  i_EX_MEM_latch,
        input  i_MEM_WB_latch,
        output o_reg_addr,
        input  i_reg_content,
        output o_mem_addr,
        input  i_mem_content,
        output o_fifo_data,
        output o_fifo_wr,
        input  i_fifo_full,
        output o_busy,
        output o_done
    );

    modport master (
        output i_start,
        output i_IF_ID_latch,
        output i_ID_EX_latch,
        output i_EX_MEM_latch,
        output i_MEM_WB_latch,
        input  o_reg_addr,
        output i_reg_content,
        input  o_mem_addr,
        output i_mem_content,
        input  o_fifo_data,
        input  o_fifo_wr,
        output i_fifo_full,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/dump_sequencer.sv
// Debug dump sequencer: snapshots the four pipeline latches, then streams latch
// words, all 32 registers and MEM_WORDS data-memory words into the TX FIFO.
module dump_sequencer #(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_WORDS      = 64
) (
    input logic           i_clk,
    input logic           i_reset,
    dump_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        LATCH,
        REG_ADDR,
        REG_WR,
        MEM_ADDR,
        MEM_WR,
        DONE
    } state_t;

    localparam logic [3:0]                LAT_LAST = 4'd12;
    localparam logic [4:0]                REG_LAST = 5'd31;
    localparam logic [MEM_ADDR_WIDTH-1:0] MEM_LAST = MEM_ADDR_WIDTH'(4 * (MEM_WORDS - 1));
    localparam logic [MEM_ADDR_WIDTH-1:0] MEM_STEP = MEM_ADDR_WIDTH'(4);

    state_t                    state;
    state_t                    state_nxt;
    logic [349:0]              snap;
    logic [415:0]              snap_words;
    logic [3:0]                lat_idx;
    logic [4:0]                reg_cnt;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]               fifo_data;
    logic                      fifo_wr;
    logic                      busy;
    logic                      done;

    // Each latch is zero-padded to a whole number of words so word i sits at bits [32i +: 32].
    assign snap_words = {25'b0, snap[349:279],
                         20'b0, snap[278:203],
                         21'b0, snap[202:64],
                         snap[63:0]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (bus.i_start) state_nxt = SNAP;
            SNAP:     state_nxt = LATCH;
            LATCH:    if (!bus.i_fifo_full && lat_idx == LAT_LAST) state_nxt = REG_ADDR;
            REG_ADDR: state_nxt = REG_WR;
            REG_WR:   if (!bus.i_fifo_full) state_nxt = (reg_cnt == REG_LAST) ? MEM_ADDR : REG_ADDR;
            MEM_ADDR: state_nxt = MEM_WR;
            MEM_WR:   if (!bus.i_fifo_full) state_nxt = (mem_addr == MEM_LAST) ? DONE : MEM_ADDR;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Counters saturate at their last value so addresses never wrap between phases.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            snap     <= '0;
            lat_idx  <= '0;
            reg_cnt  <= '0;
            mem_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        lat_idx  <= '0;
                        reg_cnt  <= '0;
                        mem_addr <= '0;
                    end
                end
                SNAP: begin
                    snap <= {bus.i_MEM_WB_latch, bus.i_EX_MEM_latch,
                             bus.i_ID_EX_latch, bus.i_IF_ID_latch};
                end
                LATCH: begin
                    if (!bus.i_fifo_full && lat_idx != LAT_LAST) lat_idx <= lat_idx + 4'd1;
                end
                REG_WR: begin
                    if (!bus.i_fifo_full && reg_cnt != REG_LAST) reg_cnt <= reg_cnt + 5'd1;
                end
                MEM_WR: begin
                    if (!bus.i_fifo_full && mem_addr != MEM_LAST) mem_addr <= mem_addr + MEM_STEP;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fifo_wr   = 1'b0;
        fifo_data = '0;
        busy      = (state != IDLE) && (state != DONE);
        done      = (state == DONE);
        unique case (state)
            LATCH: begin
                fifo_wr   = !bus.i_fifo_full;
                fifo_data = snap_words[{lat_idx, 5'd0} +: 32];
            end
            REG_WR: begin
                fifo_wr   = !bus.i_fifo_full;
                fifo_data = bus.i_reg_content;
            end
            MEM_WR: begin
                fifo_wr   = !bus.i_fifo_full;
                fifo_data = bus.i_mem_content;
            end
            default: ;
        endcase
    end

    assign bus.o_reg_addr  = reg_cnt;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_fifo_data = fifo_data;
    assign bus.o_fifo_wr   = fifo_wr;
    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
endmodule

// File: tb/tb_dump_sequencer.sv
// Scoreboard bench for dump_sequencer: expected words queued at stimulus time,
// FIFO writes collected by a monitor and compared inside each scenario task.
module tb_dump_sequencer;
    localparam int MAW   = 8;
    localparam int WORDS = 64;
    localparam int TOTAL = 13 + 32 + WORDS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          obs_cyc[$];

    dump_sequencer_if #(.MEM_ADDR_WIDTH(MAW)) bus ();

    dump_sequencer #(.MEM_ADDR_WIDTH(MAW), .MEM_WORDS(WORDS)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous register file and data memory models.
    always @(posedge clk) begin
        bus.i_reg_content <= 32'hA000_0000 + {27'b0, bus.o_reg_addr};
        bus.i_mem_content <= 32'h5EED_0000 + {{(32-MAW){1'b0}}, bus.o_mem_addr};
    end

    always @(negedge clk) begin
        if (bus.o_fifo_wr === 1'b1) begin
            obs_q.push_back(bus.o_fifo_data);
            obs_cyc.push_back(cyc);
        end
    end

    function automatic void push_latch(input logic [159:0] v, input int unsigned n);
        logic [159:0] t;
        t = v;
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back(t[31:0]);
            t = t >> 32;
        end
    endfunction

    function automatic void push_dump(input logic [63:0] a, input logic [138:0] b,
                                      input logic [75:0] c, input logic [70:0] d);
        push_latch({96'b0, a}, 2);
        push_latch({21'b0, b}, 5);
        push_latch({84'b0, c}, 3);
        push_latch({89'b0, d}, 3);
        for (int unsigned n = 0; n < 32; n++) exp_q.push_back(32'hA000_0000 + n);
        for (int unsigned k = 0; k < WORDS; k++) exp_q.push_back(32'h5EED_0000 + 4 * k);
    endfunction

    task automatic set_latches(input logic [63:0] a, input logic [138:0] b,
                               input logic [75:0] c, input logic [70:0] d);
        bus.i_IF_ID_latch  = a;
        bus.i_ID_EX_latch  = b;
        bus.i_EX_MEM_latch = c;
        bus.i_MEM_WB_latch = d;
    endtask

    task automatic pulse_start(output int drive_cyc);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        drive_cyc = cyc;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.o_busy); else passes++;
        checks++; if (bus.o_done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.o_done); else passes++;
        checks++; if (bus.o_fifo_wr !== 1'b0) $display("FAIL reset_wr got %b want 0", bus.o_fifo_wr); else passes++;
        checks++; if (bus.o_reg_addr !== 5'd0) $display("FAIL reset_reg_addr got %0d want 0", bus.o_reg_addr); else passes++;
        checks++; if (bus.o_mem_addr !== '0) $display("FAIL reset_mem_addr got %0d want 0", bus.o_mem_addr); else passes++;
        checks++; if (bus.o_fifo_data !== 32'h0) $display("FAIL reset_data got %h want 0", bus.o_fifo_data); else passes++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic_dump;
        int d;
        int done_cnt;
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        set_latches(64'h1111_2222_3333_4444, 139'b1 << 138, 76'hA_BCDE_F012_3456_789A, 71'h55_0F0F_1234_8765_4321);
        push_dump(64'h1111_2222_3333_4444, 139'b1 << 138, 76'hA_BCDE_F012_3456_789A, 71'h55_0F0F_1234_8765_4321);
        pulse_start(d);
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b1) $display("FAIL busy_after_start got %b want 1", bus.o_busy); else passes++;
        @(posedge clk); #1;
        set_latches('1, '1, '1, '1);
        done_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) begin
                done_cnt++;
                checks++; if (bus.o_busy !== 1'b0) $display("FAIL busy_in_done got %b want 0", bus.o_busy); else passes++;
            end
            if (done_cnt > 0 && bus.o_done !== 1'b1) break;
        end
        repeat (4) @(negedge clk);
        checks++; if (done_cnt !== 1) $display("FAIL done_pulses got %0d want 1", done_cnt); else passes++;
        checks++; if (obs_q.size() !== TOTAL) $display("FAIL basic_count got %0d want %0d", obs_q.size(), TOTAL); else passes++;
        if (obs_cyc.size() > 0) begin
            checks++; if (obs_cyc[0] !== d + 2) $display("FAIL first_word_latency got cyc %0d want %0d", obs_cyc[0], d + 2); else passes++;
        end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            logic [31:0] o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) $display("FAIL basic_word%0d got %h want %h", i, o, e); else passes++;
        end
    endtask

    task automatic test_backpressure;
        int  d;
        int  done_cnt;
        bit  found;
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        set_latches(64'hDEAD_BEEF_0BAD_F00D, 139'h7_1234_5678_9ABC_DEF0_1357_9BDF_2468_ACE0, 76'h1_2345_6789_ABCD_EF01, 71'h7F_FFFF_0000_AAAA_5555);
        push_dump(64'hDEAD_BEEF_0BAD_F00D, 139'h7_1234_5678_9ABC_DEF0_1357_9BDF_2468_ACE0, 76'h1_2345_6789_ABCD_EF01, 71'h7F_FFFF_0000_AAAA_5555);
        pulse_start(d);
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (obs_q.size() == 20 && bus.o_reg_addr == 5'd7) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) $display("FAIL reach_reg7 got %b want 1", found); else passes++;
        @(posedge clk); #1;
        bus.i_fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.o_fifo_wr !== 1'b0) $display("FAIL stall_wr%0d got %b want 0", c, bus.o_fifo_wr); else passes++;
            checks++; if (bus.o_reg_addr !== 5'd7) $display("FAIL stall_addr%0d got %0d want 7", c, bus.o_reg_addr); else passes++;
            checks++; if (bus.o_fifo_data !== 32'hA000_0007) $display("FAIL stall_data%0d got %h want a0000007", c, bus.o_fifo_data); else passes++;
            @(posedge clk); #1;
        end
        bus.i_fifo_full = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) done_cnt++;
            if (done_cnt > 0 && bus.o_done !== 1'b1) break;
        end
        repeat (4) @(negedge clk);
        checks++; if (done_cnt !== 1) $display("FAIL bp_done got %0d want 1", done_cnt); else passes++;
        checks++; if (obs_q.size() !== TOTAL) $display("FAIL bp_count got %0d want %0d", obs_q.size(), TOTAL); else passes++;
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            logic [31:0] o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) $display("FAIL bp_word%0d got %h want %h", i, o, e); else passes++;
        end
    endtask

    task automatic test_start_held;
        int done_cnt;
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        set_latches(64'h0123_4567_89AB_CDEF, '0, 76'hF_0000_0000_0000_0001, 71'h40_0000_0000_0000_0000);
        push_dump(64'h0123_4567_89AB_CDEF, '0, 76'hF_0000_0000_0000_0001, 71'h40_0000_0000_0000_0000);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) begin
                done_cnt++;
                bus.i_start = 1'b0;
            end
            if (done_cnt > 0 && bus.o_done !== 1'b1) break;
        end
        bus.i_start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (bus.o_busy !== 1'b0) $display("FAIL held_idle_busy%0d got %b want 0", c, bus.o_busy); else passes++;
        end
        checks++; if (done_cnt !== 1) $display("FAIL held_done got %0d want 1", done_cnt); else passes++;
        checks++; if (obs_q.size() !== TOTAL) $display("FAIL held_count got %0d want %0d", obs_q.size(), TOTAL); else passes++;
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            logic [31:0] o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) $display("FAIL held_word%0d got %h want %h", i, o, e); else passes++;
        end
    endtask

    task automatic test_reset_mid_mem;
        int d;
        int done_cnt;
        bit found;
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        set_latches(64'hCAFE_0000_0000_BABE, 139'h1, 76'h0, 71'h1);
        pulse_start(d);
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.o_mem_addr == MAW'(40)) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) $display("FAIL reach_mem10 got %b want 1", found); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.o_busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.o_busy); else passes++;
        checks++; if (bus.o_done !== 1'b0) $display("FAIL abort_done got %b want 0", bus.o_done); else passes++;
        checks++; if (bus.o_fifo_wr !== 1'b0) $display("FAIL abort_wr got %b want 0", bus.o_fifo_wr); else passes++;
        checks++; if (bus.o_reg_addr !== 5'd0) $display("FAIL abort_reg_addr got %0d want 0", bus.o_reg_addr); else passes++;
        checks++; if (bus.o_mem_addr !== '0) $display("FAIL abort_mem_addr got %0d want 0", bus.o_mem_addr); else passes++;
        checks++; if (bus.o_fifo_data !== 32'h0) $display("FAIL abort_data got %h want 0", bus.o_fifo_data); else passes++;
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.o_done !== 1'b0) $display("FAIL abort_no_done%0d got %b want 0", c, bus.o_done); else passes++;
        end
        obs_q.delete(); obs_cyc.delete();
        set_latches(64'h1357_2468_9BDF_ACE0, 139'h5_5555_AAAA_0000_FFFF_1234_4321_8888_7777, 76'h3_3333_4444_5555_6666, 71'h2A_1111_2222_3333_4444);
        push_dump(64'h1357_2468_9BDF_ACE0, 139'h5_5555_AAAA_0000_FFFF_1234_4321_8888_7777, 76'h3_3333_4444_5555_6666, 71'h2A_1111_2222_3333_4444);
        pulse_start(d);
        done_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) done_cnt++;
            if (done_cnt > 0 && bus.o_done !== 1'b1) break;
        end
        repeat (4) @(negedge clk);
        checks++; if (done_cnt !== 1) $display("FAIL restart_done got %0d want 1", done_cnt); else passes++;
        checks++; if (obs_q.size() !== TOTAL) $display("FAIL restart_count got %0d want %0d", obs_q.size(), TOTAL); else passes++;
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            logic [31:0] o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) $display("FAIL restart_word%0d got %h want %h", i, o, e); else passes++;
        end
    endtask

    initial begin
        bus.i_start     = 1'b0;
        bus.i_fifo_full = 1'b0;
        set_latches('0, '0, '0, '0);
        test_reset();
        test_basic_dump();
        test_backpressure();
        test_start_held();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
